// File: rtl/anim_sequencer.sv
// Per-player sprite animation sequencer: picks the IDLE/WALK/JUMP/ATTACK/HURT clip,
// steps frames off the vsync-derived frame_clk and drives the GPU sheet index and hitbox enable.
module anim_sequencer #(
    parameter int FRAME_DIV     = 6,
    parameter int IDLE_BASE     = 0,
    parameter int IDLE_LEN      = 4,
    parameter int WALK_BASE     = 4,
    parameter int WALK_LEN      = 6,
    parameter int JUMP_BASE     = 10,
    parameter int JUMP_LEN      = 4,
    parameter int ATK_BASE      = 14,
    parameter int ATK_LEN       = 5,
    parameter int ATK_HIT_FRAME = 2,
    parameter int HURT_BASE     = 19,
    parameter int HURT_LEN      = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       airborne,
    input  logic       attack_req,
    input  logic       hit,
    output logic [9:0] animation,
    output logic       direction,
    output logic       attack_active,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WALK   = 3'd1;
    localparam logic [2:0] S_JUMP   = 3'd2;
    localparam logic [2:0] S_ATTACK = 3'd3;
    localparam logic [2:0] S_HURT   = 3'd4;

    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [2:0]    state, state_nxt, ground_state;
    logic [7:0]    frame_idx;
    logic [DW-1:0] div_cnt;
    logic          fc_s1, fc_s2, fc_s3;
    logic          atk_prev;
    logic          tick, step, atk_edge, change, last_frame;
    logic [9:0]    base_sel;

    assign tick     = fc_s2 & ~fc_s3;
    assign step     = tick && (div_cnt == DW'(FRAME_DIV - 1));
    assign atk_edge = attack_req & ~atk_prev;

    always_comb begin
        ground_state = S_IDLE;
        if (airborne)
            ground_state = S_JUMP;
        else if (move_left ^ move_right)
            ground_state = S_WALK;
    end

    always_comb begin
        last_frame = 1'b0;
        case (state)
            S_HURT:   last_frame = (frame_idx == 8'(HURT_LEN - 1));
            S_ATTACK: last_frame = (frame_idx == 8'(ATK_LEN - 1));
            default:  last_frame = 1'b0;
        endcase
    end

    // Priority: hit, then finishing a busy clip, then attack, then ground/air selection.
    always_comb begin
        state_nxt = state;
        if (hit)
            state_nxt = S_HURT;
        else if (state == S_HURT || state == S_ATTACK)
            state_nxt = (step && last_frame) ? ground_state : state;
        else if (atk_edge)
            state_nxt = S_ATTACK;
        else
            state_nxt = ground_state;
    end

    // A hit re-entering HURT counts as a change so the clip restarts.
    assign change = hit || (state_nxt != state);

    always_comb begin
        base_sel = 10'(IDLE_BASE);
        case (state)
            S_WALK:   base_sel = 10'(WALK_BASE);
            S_JUMP:   base_sel = 10'(JUMP_BASE);
            S_ATTACK: base_sel = 10'(ATK_BASE);
            S_HURT:   base_sel = 10'(HURT_BASE);
            default:  base_sel = 10'(IDLE_BASE);
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fc_s1    <= 1'b0;
            fc_s2    <= 1'b0;
            fc_s3    <= 1'b0;
            atk_prev <= 1'b0;
        end else begin
            fc_s1    <= frame_clk;
            fc_s2    <= fc_s1;
            fc_s3    <= fc_s2;
            atk_prev <= attack_req;
        end
    end

    // A tick landing on a state change is swallowed by the counter clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            frame_idx <= 8'd0;
            div_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (change) begin
                frame_idx <= 8'd0;
                div_cnt   <= '0;
            end else if (tick) begin
                div_cnt <= step ? '0 : div_cnt + 1'b1;
                if (step) begin
                    case (state)
                        S_JUMP:
                            if (frame_idx != 8'(JUMP_LEN - 1)) frame_idx <= frame_idx + 8'd1;
                        S_WALK:
                            frame_idx <= (frame_idx == 8'(WALK_LEN - 1)) ? 8'd0 : frame_idx + 8'd1;
                        S_IDLE:
                            frame_idx <= (frame_idx == 8'(IDLE_LEN - 1)) ? 8'd0 : frame_idx + 8'd1;
                        default:
                            frame_idx <= frame_idx + 8'd1;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            animation     <= 10'(IDLE_BASE);
            direction     <= 1'b0;
            attack_active <= 1'b0;
            busy          <= 1'b0;
        end else begin
            animation     <= base_sel + {2'b00, frame_idx};
            attack_active <= (state == S_ATTACK) && (frame_idx == 8'(ATK_HIT_FRAME));
            busy          <= (state == S_ATTACK) || (state == S_HURT);
            if (state != S_ATTACK && state != S_HURT) begin
                if (move_right && !move_left)
                    direction <= 1'b0;
                else if (move_left && !move_right)
                    direction <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Scenario bench for anim_sequencer: expected {busy, attack_active, animation} words are
// queued as each frame is driven and compared once the sequencer has updated its outputs.
module tb_anim_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       airborne = 1'b0;
    logic       attack_req = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] animation;
    logic       direction;
    logic       attack_active;
    logic       busy;

    logic [11:0] exp_q[$];
    logic [11:0] exp_w, got_w;
    int          vectors = 0;
    int          errors = 0;

    anim_sequencer dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .move_left(move_left), .move_right(move_right), .airborne(airborne),
        .attack_req(attack_req), .hit(hit), .animation(animation),
        .direction(direction), .attack_active(attack_active), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Advance n clock edges, landing 2 ns after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        cyc(4);
        frame_clk = 1'b0;
        cyc(4);
    endtask

    task automatic pop_compare(input string name);
        got_w = {busy, attack_active, animation};
        exp_w = exp_q.pop_front();
        vectors++;
        if (got_w !== exp_w) begin
            errors++;
            $display("FAIL %s: got busy/aa/anim=%0b/%0b/%0d expected %0b/%0b/%0d",
                     name, got_w[11], got_w[10], got_w[9:0], exp_w[11], exp_w[10], exp_w[9:0]);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        cyc(3);
        vectors++;
        if ({busy, attack_active, direction, animation} !== 13'd0) begin
            errors++;
            $display("FAIL reset: got busy=%0b aa=%0b dir=%0b anim=%0d expected 0/0/0/0",
                     busy, attack_active, direction, animation);
        end
        Reset_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_idle();
        for (int k = 1; k <= 24; k++) begin
            exp_q.push_back({2'b00, 10'((k / 6) % 4)});
            frame_pulse();
            pop_compare("idle_frame");
        end
        vectors++;
        if (direction !== 1'b0) begin
            errors++;
            $display("FAIL idle_direction: got %0b expected 0", direction);
        end
    endtask

    task automatic test_walk();
        move_left = 1'b1;
        exp_q.push_back({2'b00, 10'd4});
        cyc(3);
        pop_compare("walk_entry");
        vectors++;
        if (direction !== 1'b1) begin
            errors++;
            $display("FAIL walk_direction: got %0b expected 1", direction);
        end
        for (int k = 1; k <= 36; k++) begin
            exp_q.push_back({2'b00, 10'(4 + (k / 6) % 6)});
            frame_pulse();
            pop_compare("walk_frame");
        end
        move_right = 1'b1;
        exp_q.push_back({2'b00, 10'd0});
        cyc(3);
        pop_compare("both_moves_idle");
        vectors++;
        if (direction !== 1'b1) begin
            errors++;
            $display("FAIL both_moves_direction: got %0b expected 1", direction);
        end
        move_right = 1'b0;
        cyc(3);
    endtask

    task automatic test_attack();
        attack_req = 1'b1;
        exp_q.push_back({2'b10, 10'd14});
        cyc(3);
        pop_compare("attack_entry");
        // Button stays held across the whole clip and beyond.
        for (int k = 1; k <= 36; k++) begin
            if (k < 30)
                exp_q.push_back({1'b1, (k / 6) == 2, 10'(14 + k / 6)});
            else
                exp_q.push_back({2'b00, 10'(4 + (k - 30) / 6)});
            frame_pulse();
            pop_compare("attack_frame");
        end
        attack_req = 1'b0;
        cyc(2);
    endtask

    task automatic test_hurt();
        attack_req = 1'b1;
        cyc(3);
        attack_req = 1'b0;
        for (int k = 1; k <= 12; k++) frame_pulse();
        exp_q.push_back({2'b11, 10'd16});
        cyc(1);
        pop_compare("hit_frame_reached");
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        exp_q.push_back({2'b10, 10'd19});
        cyc(2);
        pop_compare("hurt_entry");
        for (int k = 1; k <= 6; k++) frame_pulse();
        exp_q.push_back({2'b10, 10'd20});
        pop_compare("hurt_second_frame");
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        exp_q.push_back({2'b10, 10'd19});
        cyc(2);
        pop_compare("hurt_restart");
        for (int k = 1; k <= 18; k++) begin
            if (k < 18) exp_q.push_back({2'b10, 10'(19 + k / 6)});
            else        exp_q.push_back({2'b00, 10'd4});
            frame_pulse();
            pop_compare("hurt_frame");
        end
    endtask

    task automatic test_jump();
        move_left = 1'b0;
        cyc(3);
        airborne = 1'b1;
        exp_q.push_back({2'b00, 10'd10});
        cyc(3);
        pop_compare("jump_entry");
        for (int k = 1; k <= 60; k++) begin
            exp_q.push_back({2'b00, 10'(10 + ((k / 6 > 3) ? 3 : k / 6))});
            frame_pulse();
            pop_compare("jump_frame");
        end
        airborne = 1'b0;
        exp_q.push_back({2'b00, 10'd0});
        cyc(3);
        pop_compare("land_idle");
        move_right = 1'b1;
        cyc(3);
        move_right = 1'b0;
        vectors++;
        if (direction !== 1'b0) begin
            errors++;
            $display("FAIL face_right: got %0b expected 0", direction);
        end
        cyc(3);
    endtask

    task automatic test_reset_mid();
        attack_req = 1'b1;
        cyc(3);
        for (int k = 1; k <= 6; k++) frame_pulse();
        exp_q.push_back({2'b10, 10'd15});
        pop_compare("pre_reset_attack");
        attack_req = 1'b0;
        #1;
        Reset_n = 1'b0;
        #1;
        exp_q.push_back({2'b00, 10'd0});
        pop_compare("async_reset_mid_attack");
        cyc(2);
        Reset_n = 1'b1;
        cyc(2);
        frame_clk = 1'b1;
        cyc(100);
        frame_clk = 1'b0;
        cyc(4);
        exp_q.push_back({2'b00, 10'd0});
        pop_compare("held_high_one_tick");
        // Held-high level counted as tick 1; the sixth tick is the 5th pulse.
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back({2'b00, (k == 5) ? 10'd1 : 10'd0});
            frame_pulse();
            pop_compare("post_hold_tick");
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_walk();
        test_attack();
        test_hurt();
        test_jump();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d queued expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
- Per-player animation controller that produces the `animation` index and `direction` bit the GPU consumes for one fighter sprite.
- Sequences IDLE/WALK/JUMP/ATTACK/HURT clips from player inputs and physics status, timed off the VGA frame pulse.
- Also produces the attack hitbox-enable that the game logic uses for damage resolution.
- One instance per player, between the input/physics logic and the GPU.

Parameters:
- FRAME_DIV, 6, vsync frames per animation step (≥1).
- IDLE_BASE, 0, first sheet index of the idle clip.
- IDLE_LEN, 4, idle clip length in frames.
- WALK_BASE, 4, first sheet index of the walk clip.
- WALK_LEN, 6, walk clip length in frames.
- JUMP_BASE, 10, first sheet index of the jump clip.
- JUMP_LEN, 4, jump clip length in frames.
- ATK_BASE, 14, first sheet index of the attack clip.
- ATK_LEN, 5, attack clip length in frames.
- ATK_HIT_FRAME, 2, attack frame index during which `attack_active` is high.
- HURT_BASE, 19, first sheet index of the hurt clip.
- HURT_LEN, 3, hurt clip length in frames.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk  in  1  vsync-derived level; each rising edge is one video frame.
- move_left  in  1  level, move left.
- move_right  in  1  level, move right.
- airborne  in  1  level from physics: player not on ground.
- attack_req  in  1  level, attack button.
- hit  in  1  one-Clk pulse when the player takes damage.
- animation  out  10  GPU sprite-sheet frame index (registered).
- direction  out  1  0 = facing right, 1 = facing left (registered).
- attack_active  out  1  hitbox enable (registered).
- busy  out  1  high in ATTACK or HURT (registered).

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, frame_idx=0, div_cnt=0.
  - animation=IDLE_BASE, direction=0, attack_active=0, busy=0.
  - Edge-detect registers cleared.
- Release is synchronous to Clk. Reset mid-clip returns to IDLE immediately.
- frame_clk:
  - Registered with a 2-flop synchronizer.
  - tick = one-Clk pulse on each synchronized rising edge.
  - frame_clk held high produces exactly one tick.
- Divider:
  - div_cnt counts ticks 0..FRAME_DIV-1.
  - step is asserted when tick && div_cnt==FRAME_DIV-1; div_cnt then wraps to 0.
- attack_req is rising-edge detected (atk_edge). Holding the button does not repeat attacks.
- States and priority (evaluated every Clk; highest first):
  - hit → HURT, from any state including HURT (restarts the clip).
  - In HURT: on step, frame_idx++. After the step leaving frame HURT_LEN-1, go to the ground/air state (JUMP if airborne, else WALK/IDLE).
  - In ATTACK: ignores moves, airborne and atk_edge. On step, frame_idx++. After frame ATK_LEN-1 completes, go to the ground/air state.
  - atk_edge in IDLE/WALK/JUMP → ATTACK.
  - airborne → JUMP. Frames advance 0..JUMP_LEN-1 on step, then hold JUMP_LEN-1 until airborne=0.
  - move_left XOR move_right → WALK. Frames loop 0..WALK_LEN-1, wrapping on step.
  - Otherwise IDLE. Frames loop 0..IDLE_LEN-1.
- Any state change (including a HURT restart): frame_idx=0 and div_cnt=0 on the same Clk edge, so the first frame shows for a full FRAME_DIV.
- A tick coincident with a state change is consumed by the reset of div_cnt; no step occurs.
- Same-state transitions (e.g. IDLE→IDLE) do not reset counters.
- Outputs, registered one Clk after the state/frame update:
  - animation = zero-extended base(state) + frame_idx, 10-bit, no overflow by construction.
  - attack_active = (state==ATTACK && frame_idx==ATK_HIT_FRAME).
  - busy = state∈{ATTACK,HURT}.
- direction:
  - Updated only in IDLE/WALK/JUMP: move_right only → 0; move_left only → 1; both or neither → hold.
  - Frozen in ATTACK and HURT.

Test Plan:
- Reset, then 24 frame_clk edges, no inputs → animation steps 0,1,2,3,0 every 6 frames; direction=0; busy=0.
- move_left held → animation=4 within 3 Clk of the input; direction=1; after 36 frames animation wraps 9→4. Both moves held → direction holds 1, state IDLE.
- attack_req pulse in WALK → animation 14..18, 6 frames each; attack_active high only while animation=16; busy=1 throughout; then returns to WALK (animation=4). attack_req held across the clip → no second attack.
- hit while animation=16 → animation=19 next cycles; attack_active drops; HURT runs 19,20,21; second hit at 20 → restarts at 19.
- airborne high for 60 frames → animation 10,11,12,13 then holds 13; airborne low → IDLE, animation=0.
- Reset_n asserted mid-ATTACK (async, between Clk edges) → outputs immediately animation=0, busy=0, attack_active=0; frame_clk held high 100 Clk → exactly one tick counted.
